// File: rtl/ddr_axi_limiter_if.sv
// AXI4 channel bundle for the DDR limiter: AW/W/AR requests, B/R responses.
// master drives requests and response readies; slave drives the opposite set.
interface ddr_axi_limiter_if #(
  parameter int DataWidth = 128,
  parameter int AddrWidth = 27,
  parameter int IdWidth   = 8
);
  localparam int AxW = IdWidth + AddrWidth + 8 + 3 + 2;
  localparam int WW  = DataWidth + DataWidth / 8 + 1;
  localparam int BW  = IdWidth + 2;
  localparam int RW  = IdWidth + DataWidth + 3;

  logic           aw_valid;
  logic           aw_ready;
  logic [AxW-1:0] aw;
  logic           w_valid;
  logic           w_ready;
  logic [WW-1:0]  w;
  logic           ar_valid;
  logic           ar_ready;
  logic [AxW-1:0] ar;
  logic           b_valid;
  logic           b_ready;
  logic [BW-1:0]  b;
  logic           r_valid;
  logic           r_ready;
  logic [RW-1:0]  r;

  modport master (
    output aw_valid, aw, w_valid, w, ar_valid, ar,
    output b_ready, r_ready,
    input  aw_ready, w_ready, ar_ready,
    input  b_valid, b, r_valid, r
  );

  modport slave (
    input  aw_valid, aw, w_valid, w, ar_valid, ar,
    input  b_ready, r_ready,
    output aw_ready, w_ready, ar_ready,
    output b_valid, b, r_valid, r
  );
endinterface

// File: rtl/ddr_axi_limiter.sv
// Outstanding-transaction limiter between the TL-to-AXI adapter (s) and
// the DDR clock converter (m). Ports: clk_i, rst_i (sync, active-high),
// s (slave side, from adapter), m (master side, to converter),
// drain_i (stop new AR/AW), idle_o (drained), err_o (sticky underflow).
module ddr_axi_limiter #(
  parameter int DataWidth = 128,
  parameter int AddrWidth = 27,
  parameter int IdWidth   = 8,
  parameter int MaxReads  = 8,
  parameter int MaxWrites = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ddr_axi_limiter_if.slave   s,
  ddr_axi_limiter_if.master  m,
  input  logic               drain_i,
  output logic               idle_o,
  output logic               err_o
);
  localparam int RdW = $clog2(MaxReads + 1);
  localparam int WrW = $clog2(MaxWrites + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DRAINED
  } state_t;

  state_t         state, state_n;
  logic [RdW-1:0] rd_cnt, rd_cnt_n;
  logic [WrW-1:0] wr_cnt, wr_cnt_n;
  logic [WrW-1:0] wp_cnt, wp_cnt_n;
  logic           err_q, err_n;
  logic           idle_q;

  logic rd_ok, wr_ok, w_ok;
  logic ar_hs, aw_hs, wl_hs, b_hs, rl_hs;

  assign rd_ok = (rd_cnt < RdW'(MaxReads)) && (state == RUN);
  assign wr_ok = (wr_cnt < WrW'(MaxWrites)) && (state == RUN);
  // registered count only: a W in the same cycle as its AW waits one cycle
  assign w_ok  = (wp_cnt != '0);

  assign m.ar_valid = s.ar_valid & rd_ok;
  assign s.ar_ready = m.ar_ready & rd_ok;
  assign m.ar       = s.ar;

  assign m.aw_valid = s.aw_valid & wr_ok;
  assign s.aw_ready = m.aw_ready & wr_ok;
  assign m.aw       = s.aw;

  assign m.w_valid  = s.w_valid & w_ok;
  assign s.w_ready  = m.w_ready & w_ok;
  assign m.w        = s.w;

  assign s.b_valid  = m.b_valid;
  assign m.b_ready  = s.b_ready;
  assign s.b        = m.b;

  assign s.r_valid  = m.r_valid;
  assign m.r_ready  = s.r_ready;
  assign s.r        = m.r;

  assign ar_hs = s.ar_valid & m.ar_ready & rd_ok;
  assign aw_hs = s.aw_valid & m.aw_ready & wr_ok;
  assign wl_hs = s.w_valid & m.w_ready & w_ok & s.w[0];
  assign b_hs  = m.b_valid & s.b_ready;
  assign rl_hs = m.r_valid & s.r_ready & m.r[0];

  // a decrement with nothing outstanding holds at zero and flags err
  always_comb begin
    rd_cnt_n = rd_cnt;
    wr_cnt_n = wr_cnt;
    wp_cnt_n = wp_cnt;
    err_n    = err_q;
    unique case ({ar_hs, rl_hs})
      2'b10: rd_cnt_n = rd_cnt + RdW'(1);
      2'b01: begin
        if (rd_cnt == '0) err_n = 1'b1;
        else rd_cnt_n = rd_cnt - RdW'(1);
      end
      default: rd_cnt_n = rd_cnt;
    endcase
    unique case ({aw_hs, b_hs})
      2'b10: wr_cnt_n = wr_cnt + WrW'(1);
      2'b01: begin
        if (wr_cnt == '0) err_n = 1'b1;
        else wr_cnt_n = wr_cnt - WrW'(1);
      end
      default: wr_cnt_n = wr_cnt;
    endcase
    // saturate: spurious B could otherwise let wpend run past wr_cnt
    unique case ({aw_hs, wl_hs})
      2'b10: begin
        if (wp_cnt != '1) wp_cnt_n = wp_cnt + WrW'(1);
      end
      2'b01: begin
        if (wp_cnt == '0) err_n = 1'b1;
        else wp_cnt_n = wp_cnt - WrW'(1);
      end
      default: wp_cnt_n = wp_cnt;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN: begin
        if (drain_i) state_n = DRAIN;
      end
      DRAIN: begin
        if (!drain_i) state_n = RUN;
        else if (rd_cnt_n == '0 && wr_cnt_n == '0 &&
                 wp_cnt_n == '0)
          state_n = DRAINED;
      end
      DRAINED: begin
        if (!drain_i) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= RUN;
      rd_cnt <= '0;
      wr_cnt <= '0;
      wp_cnt <= '0;
      err_q  <= 1'b0;
      idle_q <= 1'b0;
    end else begin
      state  <= state_n;
      rd_cnt <= rd_cnt_n;
      wr_cnt <= wr_cnt_n;
      wp_cnt <= wp_cnt_n;
      err_q  <= err_n;
      idle_q <= (state_n == DRAINED);
    end
  end

  assign idle_o = idle_q;
  assign err_o  = err_q;
endmodule

// File: tb/tb_ddr_axi_limiter.sv
// Bench for ddr_axi_limiter: vector table, corner sequences and
// randomized traffic against a counting reference model.
module tb_ddr_axi_limiter;
  localparam int DW  = 128;
  localparam int AW  = 27;
  localparam int IW  = 8;
  localparam int MAXR = 8;
  localparam int MAXW = 8;
  localparam int AXW = IW + AW + 13;
  localparam int WW  = DW + DW / 8 + 1;
  localparam int BW  = IW + 2;
  localparam int RW  = IW + DW + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drain = 1'b0;
  logic idle, err;

  always #5 clk = ~clk;

  ddr_axi_limiter_if #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW)) up ();
  ddr_axi_limiter_if #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW)) dn ();

  ddr_axi_limiter #(
    .DataWidth(DW), .AddrWidth(AW), .IdWidth(IW),
    .MaxReads(MAXR), .MaxWrites(MAXW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .s(up), .m(dn),
    .drain_i(drain), .idle_o(idle), .err_o(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk1(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkw(string nm, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    bit drain, arv, awv, wv, wl, bv, rv, rl, mrdy, srdy;
    bit e_ar, e_aw, e_w, e_idle, e_err;
  } vec_t;

  task automatic drive(vec_t v);
    drain       = v.drain;
    up.ar_valid = v.arv;
    up.aw_valid = v.awv;
    up.w_valid  = v.wv;
    up.ar       = '0;
    up.aw       = '0;
    up.w        = WW'(v.wl);
    dn.b_valid  = v.bv;
    dn.b        = '0;
    dn.r_valid  = v.rv;
    dn.r        = RW'(v.rl);
    dn.ar_ready = v.mrdy;
    dn.aw_ready = v.mrdy;
    dn.w_ready  = v.mrdy;
    up.b_ready  = v.srdy;
    up.r_ready  = v.srdy;
  endtask

  task automatic do_reset();
    vec_t v;
    v = '0;
    v.arv = 1'b1;
    v.mrdy = 1'b1;
    drive(v);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("rst_m_ar_valid", dn.ar_valid, 1'b1);
    chk1("rst_s_ar_ready", up.ar_ready, 1'b1);
    chk1("rst_s_w_ready", up.w_ready, 1'b0);
    chk1("rst_idle", idle, 1'b0);
    chk1("rst_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive('0);
  endtask

  vec_t tbl[20];

  // reference model: outstanding counts as plain integers
  int  mrd, mwr, mwp;
  bit  mdraining, mdrained, merr;

  task automatic model_reset();
    mrd = 0; mwr = 0; mwp = 0;
    mdraining = 0; mdrained = 0; merr = 0;
  endtask

  function automatic logic [159:0] rnd160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [159:0] tmp;
    vec_t v;
    int acc;
    bit run, ar_ok, aw_ok, w_ok;
    bit ar_hs, aw_hs, w_hs, b_hs, r_hs;
    int nrd, nwr, nwp;

    //        drn ar aw w  wl b  r  rl mr sr | ar aw w idl err
    tbl[0]  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[2]  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    tbl[3]  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    tbl[4]  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    tbl[5]  = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    tbl[6]  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[7]  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[8]  = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[9]  = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[10] = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[11] = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[12] = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[13] = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[14] = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0};
    tbl[15] = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[16] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[17] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[18] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1};
    tbl[19] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1};

    drive('0);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i]);
      #1;
      chk1($sformatf("tbl%0d_ar_ready", i), up.ar_ready, tbl[i].e_ar);
      chk1($sformatf("tbl%0d_aw_ready", i), up.aw_ready, tbl[i].e_aw);
      chk1($sformatf("tbl%0d_w_ready", i), up.w_ready, tbl[i].e_w);
      chk1($sformatf("tbl%0d_idle", i), idle, tbl[i].e_idle);
      chk1($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      @(posedge clk);
      @(negedge clk);
    end

    // reset clears sticky err (checked inside do_reset)
    do_reset();

    // nine back-to-back ARs with R stalled: eight accepted
    acc = 0;
    v = '0;
    v.arv = 1'b1;
    v.mrdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(v);
      #1;
      if (up.ar_ready === 1'b1) acc++;
      if (i == 8) chk1("ar9_blocked", up.ar_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    chkw("ar_accepted", 256'(acc), 256'(MAXR));
    v.rv = 1'b1; v.rl = 1'b1; v.srdy = 1'b1;
    drive(v);
    #1;
    chk1("ar9_still_blocked", up.ar_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    v.rv = 1'b0; v.rl = 1'b0;
    drive(v);
    #1;
    chk1("ar9_after_rlast", up.ar_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    // back at 8: retire one, then AR and R-last together keep 7
    v.arv = 1'b0; v.rv = 1'b1; v.rl = 1'b1;
    drive(v);
    @(posedge clk);
    @(negedge clk);
    v.arv = 1'b1;
    drive(v);
    #1;
    chk1("ar_rlast_same_cycle", up.ar_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    v.rv = 1'b0; v.rl = 1'b0;
    drive(v);
    #1;
    chk1("ar_fills_to_max", up.ar_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(v);
    #1;
    chk1("ar_full_again", up.ar_ready, 1'b0);
    chk1("no_err_simul", err, 1'b0);

    // randomized traffic against the counting model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) drain = ~drain;
      up.ar_valid = 1'($urandom_range(1));
      up.aw_valid = 1'($urandom_range(1));
      up.w_valid  = 1'($urandom_range(1));
      dn.ar_ready = 1'($urandom_range(1));
      dn.aw_ready = 1'($urandom_range(1));
      dn.w_ready  = 1'($urandom_range(1));
      up.b_ready  = 1'($urandom_range(1));
      up.r_ready  = 1'($urandom_range(1));
      dn.b_valid  = (mwr > 0) && ($urandom_range(1) == 1);
      dn.r_valid  = (mrd > 0) && ($urandom_range(1) == 1);
      tmp = rnd160(); up.ar = tmp[AXW-1:0];
      tmp = rnd160(); up.aw = tmp[AXW-1:0];
      tmp = rnd160(); up.w  = tmp[WW-1:0];
      up.w[0] = ($urandom_range(3) == 0);
      tmp = rnd160(); dn.b  = tmp[BW-1:0];
      tmp = rnd160(); dn.r  = tmp[RW-1:0];
      dn.r[0] = ($urandom_range(3) == 0);
      #1;
      run   = !mdraining && !mdrained;
      ar_ok = run && (mrd < MAXR);
      aw_ok = run && (mwr < MAXW);
      w_ok  = (mwp > 0);
      chk1("rnd_m_ar_valid", dn.ar_valid, up.ar_valid & ar_ok);
      chk1("rnd_s_ar_ready", up.ar_ready, dn.ar_ready & ar_ok);
      chk1("rnd_m_aw_valid", dn.aw_valid, up.aw_valid & aw_ok);
      chk1("rnd_s_aw_ready", up.aw_ready, dn.aw_ready & aw_ok);
      chk1("rnd_m_w_valid", dn.w_valid, up.w_valid & w_ok);
      chk1("rnd_s_w_ready", up.w_ready, dn.w_ready & w_ok);
      chk1("rnd_s_b_valid", up.b_valid, dn.b_valid);
      chk1("rnd_m_b_ready", dn.b_ready, up.b_ready);
      chk1("rnd_s_r_valid", up.r_valid, dn.r_valid);
      chk1("rnd_m_r_ready", dn.r_ready, up.r_ready);
      chkw("rnd_ar_pay", 256'(dn.ar), 256'(up.ar));
      chkw("rnd_aw_pay", 256'(dn.aw), 256'(up.aw));
      chkw("rnd_w_pay", 256'(dn.w), 256'(up.w));
      chkw("rnd_b_pay", 256'(up.b), 256'(dn.b));
      chkw("rnd_r_pay", 256'(up.r), 256'(dn.r));
      chk1("rnd_idle", idle, mdrained);
      chk1("rnd_err", err, merr);
      ar_hs = up.ar_valid && dn.ar_ready && ar_ok;
      aw_hs = up.aw_valid && dn.aw_ready && aw_ok;
      w_hs  = up.w_valid && dn.w_ready && w_ok && up.w[0];
      b_hs  = dn.b_valid && up.b_ready;
      r_hs  = dn.r_valid && up.r_ready && dn.r[0];
      nrd = mrd + int'(ar_hs) - int'(r_hs);
      nwr = mwr + int'(aw_hs) - int'(b_hs);
      nwp = mwp + int'(aw_hs) - int'(w_hs);
      if (nrd < 0) begin nrd = 0; merr = 1; end
      if (nwr < 0) begin nwr = 0; merr = 1; end
      if (nwp < 0) begin nwp = 0; merr = 1; end
      if (run) begin
        if (drain) mdraining = 1;
      end else if (mdraining) begin
        if (!drain) mdraining = 0;
        else if (nrd == 0 && nwr == 0 && nwp == 0) begin
          mdraining = 0;
          mdrained = 1;
        end
      end else if (!drain) begin
        mdrained = 0;
      end
      mrd = nrd; mwr = nwr; mwp = nwp;
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
